// File: rtl/cpu_defs.sv
// Shared ALU datapath definitions: default operand width and divider FSM encodings.
package cpu_defs;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/divider_if.sv
// Divider request/response bundle: operands plus start in, results, flags and handshake out.
interface divider_if #(parameter int WIDTH = cpu_defs::DATA_W);
  logic             start;
  logic [WIDTH-1:0] dividend_hi;
  logic [WIDTH-1:0] dividend_lo;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, dividend_hi, dividend_lo, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend_hi, dividend_lo, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, subtract divisor when it fits.
module div_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH:0]   i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_r,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH+1:0] w_sh;
  logic             w_ge;

  assign w_sh = {i_r, i_q[WIDTH-1]};
  assign w_ge = (w_sh >= {2'b00, i_div});

  // When the subtract happens the result is below the divisor, so the low bits suffice.
  always_comb begin
    o_r = w_sh[WIDTH:0];
    o_q = {i_q[WIDTH-2:0], 1'b0};
    if (w_ge) begin
      o_r = w_sh[WIDTH:0] - {1'b0, i_div};
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/divider.sv
// Sequential 2W-by-W unsigned restoring divider, one quotient bit per clock, with up-front
// divide-by-zero and quotient-overflow detection.
module divider
  import cpu_defs::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;
  logic             r_ovf;

  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r   (r_rem),
    .i_q   (r_q),
    .i_div (r_div),
    .o_r   (w_rem_nxt),
    .o_q   (w_q_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (bus.start) begin
            r_busy <= 1'b1;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
            r_div  <= bus.divisor;
            if (bus.divisor == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_dz    <= 1'b1;
              r_quot  <= '1;
              r_remo  <= bus.dividend_lo;
            end else if (bus.dividend_hi >= bus.divisor) begin
              // Quotient would not fit in WIDTH bits.
              r_state <= DONE;
              r_done  <= 1'b1;
              r_ovf   <= 1'b1;
              r_quot  <= '1;
              r_remo  <= bus.dividend_hi;
            end else begin
              r_state <= RUN;
              r_rem   <= {1'b0, bus.dividend_hi};
              r_q     <= bus.dividend_lo;
              r_cnt   <= '0;
            end
          end
        end
        RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_quot  <= w_q_nxt;
            r_remo  <= w_rem_nxt[WIDTH-1:0];
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remo;
  assign bus.div_zero  = r_dz;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider against a plain-arithmetic reference model.
module tb_divider;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [W-1:0] obs_q, obs_r;

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // {quotient, remainder, div_zero, overflow}
  function automatic logic [2*W+1:0] ref_div(input logic [W-1:0] hi, lo, d);
    logic [2*W-1:0] dvd;
    logic [2*W-1:0] q, r;
    dvd = {hi, lo};
    if (d == 0)  return {{W{1'b1}}, lo, 1'b1, 1'b0};
    if (hi >= d) return {{W{1'b1}}, hi, 1'b0, 1'b1};
    q = dvd / {16'd0, d};
    r = dvd % {16'd0, d};
    return {q[W-1:0], r[W-1:0], 1'b0, 1'b0};
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_q"},    32'(bus.quotient), 32'd0);
    chk({tag, "_r"},    32'(bus.remainder), 32'd0);
    chk({tag, "_dz"},   32'(bus.div_zero), 32'd0);
    chk({tag, "_ov"},   32'(bus.overflow), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] hi, lo, d);
    logic [2*W+1:0] e;
    int lat;
    int exp_lat;
    e = ref_div(hi, lo, d);
    exp_lat = (e[1] | e[0]) ? 1 : W + 1;
    @(posedge clk); #1;
    bus.dividend_hi = hi; bus.dividend_lo = lo; bus.divisor = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    // Operands may change once accepted.
    bus.dividend_hi = W'($urandom); bus.dividend_lo = W'($urandom); bus.divisor = W'($urandom);
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    obs_q = bus.quotient;
    obs_r = bus.remainder;
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_q"},    32'(bus.quotient), 32'(e[2*W+1:W+2]));
    chk({tag, "_r"},    32'(bus.remainder), 32'(e[W+1:2]));
    chk({tag, "_dz"},   32'(bus.div_zero), 32'(e[1]));
    chk({tag, "_ov"},   32'(bus.overflow), 32'(e[0]));
    @(posedge clk); #1;
    chk({tag, "_dn0"},  32'(bus.done), 32'd0);
    chk({tag, "_bz0"},  32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] p, pc;
    logic [W-1:0] a, b, c;
    int k;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend_hi = '0; bus.dividend_lo = '0; bus.divisor = '0;
    #1;
    check_idle_zero("rst");
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_op("d100_7", 16'h0000, 16'd100, 16'd7);
    chk("d100_7_qv", 32'(obs_q), 32'd14);
    chk("d100_7_rv", 32'(obs_r), 32'd2);
    run_op("big", 16'hFFFE, 16'h0001, 16'hFFFF);
    chk("big_qv", 32'(obs_q), 32'hFFFF);
    chk("big_rv", 32'(obs_r), 32'd0);
    run_op("dz", 16'h0000, 16'h1234, 16'h0000);
    chk("dz_rv", 32'(obs_r), 32'h1234);
    run_op("ovf", 16'd5, 16'h0000, 16'd5);
    chk("ovf_rv", 32'(obs_r), 32'd5);
    run_op("post_err", 16'h0001, 16'h0000, 16'h0002);

    // start pulses during RUN and DONE must be ignored
    @(posedge clk); #1;
    bus.dividend_hi = 0; bus.dividend_lo = 100; bus.divisor = 7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.dividend_lo = 50; bus.divisor = 0; bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("ign_run_done", 32'(bus.done), 32'd1);
    chk("ign_run_q", 32'(bus.quotient), 32'd14);
    chk("ign_run_r", 32'(bus.remainder), 32'd2);
    chk("ign_run_dz", 32'(bus.div_zero), 32'd0);
    bus.dividend_hi = 3; bus.dividend_lo = 0; bus.divisor = 3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ign_done_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk("ign_done_busy2", 32'(bus.busy), 32'd0);
    chk("ign_done_ov", 32'(bus.overflow), 32'd0);
    chk("ign_done_q", 32'(bus.quotient), 32'd14);

    // reset mid-RUN
    @(posedge clk); #1;
    bus.dividend_hi = 0; bus.dividend_lo = 100; bus.divisor = 7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", 32'(bus.busy), 32'd0);
    run_op("after_rst", 16'h0000, 16'd100, 16'd7);
    chk("after_rst_qv", 32'(obs_q), 32'd14);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom_range(1, 65535));
      c = W'($urandom_range(0, int'(b) - 1));
      p = 32'(a) * 32'(b);
      pc = p + 32'(c);
      run_op("rnd_p", p[31:16], p[15:0], b);
      chk("rnd_p_qa", 32'(obs_q), 32'(a));
      chk("rnd_p_r0", 32'(obs_r), 32'd0);
      run_op("rnd_pc", pc[31:16], pc[15:0], b);
      chk("rnd_pc_qa", 32'(obs_q), 32'(a));
      chk("rnd_pc_rc", 32'(obs_r), 32'(c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
